// File: rtl/dmr_instr_fork_join_pkg.sv
// Shared types for the DMR instruction fork/join stage.
package dmr_pkg;

    // Top-level controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RETRY = 2'd2
    } fork_join_state_e;

endpackage

// File: rtl/dmr_lane_tracker.sv
// Per-lane completion tracker: remembers whether a lane has answered the
// current fetch and buffers its word so late lanes can be compared against it.
module dmr_lane_tracker #(
    parameter type data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clr_i,        // drop done flag (transaction finished or restarted)
    input  logic  req_valid_i,  // controller wants this lane requested this cycle
    input  logic  ready_i,
    input  data_t data_i,
    output logic  valid_o,      // lane address valid
    output logic  done_o,       // lane done including a handshake this cycle
    output data_t data_o        // buffered word if done earlier, else live word
);

    logic  done_q, done_d;
    data_t buf_q, buf_d;
    logic  hit_s;

    // A lane that already answered is not requested again
    assign valid_o = req_valid_i & ~done_q;
    assign hit_s   = valid_o & ready_i;
    assign done_o  = done_q | hit_s;
    assign data_o  = done_q ? buf_q : data_i;

    // Next-state for done flag and data buffer
    always_comb begin
        done_d = done_q;
        buf_d  = buf_q;
        if (clr_i) begin
            done_d = 1'b0;
        end else if (hit_s) begin
            done_d = 1'b1;
            buf_d  = data_i;
        end else begin
            done_d = done_q;
        end
    end

    // Done flag and data buffer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            buf_q  <= '0;
        end else begin
            done_q <= done_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/dmr_instr_fork_join.sv
// Forks one instruction fetch to NUM_OUT redundant responders, waits for all
// lanes, and returns the word only when every lane agrees with lane 0.
// Mismatches are retried; exhausted retries or a timeout raise sticky fatal.
module dmr_instr_fork_join
    import dmr_pkg::*;
#(
    parameter type         addr_t        = logic,
    parameter type         data_t        = logic,
    parameter int unsigned NUM_OUT       = 2,
    parameter int unsigned MaxRetries    = 1,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  addr_t                addr_i,
    output data_t                data_o,
    output logic [NUM_OUT-1:0]   valid_o,
    input  logic [NUM_OUT-1:0]   ready_i,
    output addr_t                addr_o [NUM_OUT],
    input  data_t                data_i [NUM_OUT],
    output logic                 error_o,
    output logic                 fatal_o
);

    localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam logic [TW-1:0] TimerLimit = TW'(TimeoutCycles - 1);

    fork_join_state_e fsm_q, fsm_d;
    addr_t            addr_q, addr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             fatal_q, fatal_d;

    logic               req_valid_s;
    logic               clr_s;
    logic [NUM_OUT-1:0] lane_valid_s;
    logic [NUM_OUT-1:0] lane_done_s;
    data_t              lane_data_s [NUM_OUT];
    logic               all_done_s;
    logic               match_s;
    logic               active_s;
    logic               req_same_s;
    logic               timeout_s;
    logic               ready_s;
    logic               error_s;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
        dmr_lane_tracker #(.data_t(data_t)) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clr_i       (clr_s),
            .req_valid_i (req_valid_s),
            .ready_i     (ready_i[g]),
            .data_i      (data_i[g]),
            .valid_o     (lane_valid_s[g]),
            .done_o      (lane_done_s[g]),
            .data_o      (lane_data_s[g])
        );
        assign valid_o[g] = rst_ni & lane_valid_s[g];
        assign addr_o[g]  = (fsm_q == IDLE) ? addr_i : addr_q;
    end

    assign all_done_s = &lane_done_s;
    assign active_s   = ((fsm_q == IDLE) && valid_i) || (fsm_q == WAIT);
    assign req_same_s = (fsm_q == IDLE) ? valid_i : (valid_i && (addr_i == addr_q));
    assign timeout_s  = (TimeoutCycles != 0) && (fsm_q != IDLE) &&
                        (timer_q == TimerLimit) && !all_done_s;
    // Anything other than staying in WAIT ends (or restarts) lane tracking
    assign clr_s      = (fsm_d != WAIT);

    assign ready_o = rst_ni & ready_s;
    assign error_o = rst_ni & error_s;
    assign fatal_o = fatal_q;
    assign data_o  = lane_data_s[0];

    // Full-word equality of every lane against lane 0
    always_comb begin
        match_s = 1'b1;
        for (int unsigned i = 1; i < NUM_OUT; i++) begin
            match_s = match_s & (lane_data_s[i] == lane_data_s[0]);
        end
    end

    // Output decode: which lanes the controller requests in each state
    always_comb begin
        case (fsm_q)
            IDLE:    req_valid_s = valid_i;
            WAIT:    req_valid_s = 1'b1;
            RETRY:   req_valid_s = 1'b0;
            default: req_valid_s = 1'b0;
        endcase
    end

    // Next-state, completion, mismatch/retry and timeout handling
    always_comb begin
        fsm_d   = fsm_q;
        retry_d = retry_q;
        fatal_d = fatal_q;
        ready_s = 1'b0;
        error_s = 1'b0;
        case (fsm_q)
            IDLE, WAIT: begin
                if (active_s && all_done_s) begin
                    if (match_s) begin
                        ready_s = req_same_s;
                        fsm_d   = IDLE;
                    end else begin
                        error_s = 1'b1;
                        if (32'(retry_q) < MaxRetries) begin
                            retry_d = retry_q + RW'(1);
                            fsm_d   = RETRY;
                        end else begin
                            fatal_d = 1'b1;
                            ready_s = req_same_s;
                            fsm_d   = IDLE;
                        end
                    end
                end else if (timeout_s) begin
                    error_s = 1'b1;
                    fatal_d = 1'b1;
                    fsm_d   = IDLE;
                end else if (active_s) begin
                    fsm_d = WAIT;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RETRY: begin
                if (timeout_s) begin
                    error_s = 1'b1;
                    fatal_d = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    fsm_d = WAIT;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (fsm_d == IDLE) begin
            retry_d = '0;
        end else begin
            retry_d = retry_d;
        end
    end

    // Address latch and timer; timer saturates so a retry at the limit still times out
    always_comb begin
        if ((fsm_q == IDLE) && valid_i) begin
            addr_d = addr_i;
        end else begin
            addr_d = addr_q;
        end
        if ((fsm_d == IDLE) || (fsm_q == IDLE)) begin
            timer_d = '0;
        end else if ((TimeoutCycles != 0) && (timer_q != TimerLimit)) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Controller state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            addr_q  <= '0;
            timer_q <= '0;
            retry_q <= '0;
            fatal_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            fatal_q <= fatal_d;
        end
    end

endmodule

// File: tb/tb_dmr_instr_fork_join.sv
// Directed bench for dmr_instr_fork_join: expected responses go into a
// scoreboard queue; a negedge monitor pops and checks every ready_o beat.
module tb_dmr_instr_fork_join;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] addr_i;
    logic [31:0] data_o;
    logic [1:0]  valid_o;
    logic [1:0]  ready_i;
    logic [15:0] addr_o [2];
    logic [31:0] data_i [2];
    logic        error_o;
    logic        fatal_o;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    logic [31:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    dmr_instr_fork_join #(
        .addr_t        (logic [15:0]),
        .data_t        (logic [31:0]),
        .NUM_OUT       (2),
        .MaxRetries    (1),
        .TimeoutCycles (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .addr_i  (addr_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .addr_o  (addr_o),
        .data_i  (data_i),
        .error_o (error_o),
        .fatal_o (fatal_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [15:0] a, input logic [1:0] r,
                       input logic [31:0] d0, input logic [31:0] d1);
        valid_i   = v;
        addr_i    = a;
        ready_i   = r;
        data_i[0] = d0;
        data_i[1] = d1;
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every accepted response must match the head of the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1) begin
                if (error_o === 1'b1) err_seen++;
                if (ready_o === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL resp_unexpected: got data %0h want no response", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_o !== e) begin
                            bad++;
                            $display("FAIL resp_data: got %0h want %0h", data_o, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_valid", {30'd0, valid_o}, 32'd0);
        chk("rst_error", {31'd0, error_o}, 32'd0);
        chk("rst_fatal", {31'd0, fatal_o}, 32'd0);
        nxt();
        nxt();
        rst_ni = 1'b1;
        nxt();

        // Zero-latency agreement
        drv(1'b1, 16'h100, 2'b11, 32'hA, 32'hA);
        exp_q.push_back(32'hA);
        #2;
        chk("zl_ready", {31'd0, ready_o}, 32'd1);
        chk("zl_error", {31'd0, error_o}, 32'd0);
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        nxt();

        // Skewed lanes: lane 0 at cycle 0, lane 1 at cycle 3
        drv(1'b1, 16'h100, 2'b01, 32'h13, 32'h99);
        #2;
        chk("skew_c0_valid", {30'd0, valid_o}, 32'h3);
        chk("skew_c0_ready", {31'd0, ready_o}, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            nxt();
            drv(1'b1, 16'h100, 2'b00, 32'h77, 32'h99);
            #2;
            chk("skew_wait_valid", {30'd0, valid_o}, 32'h2);
            chk("skew_wait_addr1", {16'd0, addr_o[1]}, 32'h100);
            chk("skew_wait_ready", {31'd0, ready_o}, 32'd0);
        end
        nxt();
        drv(1'b1, 16'h100, 2'b10, 32'h77, 32'h13);
        exp_q.push_back(32'h13);
        #2;
        chk("skew_c3_ready", {31'd0, ready_o}, 32'd1);
        chk("skew_c3_addr1", {16'd0, addr_o[1]}, 32'h100);
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("skew_idle_valid", {30'd0, valid_o}, 32'h0);
        nxt();

        // Mismatch, retry, then agreement
        drv(1'b1, 16'h100, 2'b11, 32'h5, 32'h6);
        #2;
        chk("retry_err", {31'd0, error_o}, 32'd1);
        chk("retry_ready0", {31'd0, ready_o}, 32'd0);
        nxt();
        drv(1'b1, 16'h100, 2'b00, 32'h0, 32'h0);
        #2;
        chk("retry_bubble_valid", {30'd0, valid_o}, 32'h0);
        chk("retry_bubble_err", {31'd0, error_o}, 32'd0);
        nxt();
        drv(1'b1, 16'h100, 2'b11, 32'h5, 32'h5);
        exp_q.push_back(32'h5);
        #2;
        chk("retry_reissue_valid", {30'd0, valid_o}, 32'h3);
        chk("retry_reissue_addr0", {16'd0, addr_o[0]}, 32'h100);
        chk("retry_ok_ready", {31'd0, ready_o}, 32'd1);
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("retry_ok_fatal", {31'd0, fatal_o}, 32'd0);
        nxt();

        // Retries exhausted: fatal, lane-0 word returned
        drv(1'b1, 16'h200, 2'b11, 32'h1, 32'h2);
        #2;
        chk("exh_err1", {31'd0, error_o}, 32'd1);
        nxt();
        drv(1'b1, 16'h200, 2'b00, 32'h0, 32'h0);
        nxt();
        drv(1'b1, 16'h200, 2'b11, 32'h3, 32'h4);
        exp_q.push_back(32'h3);
        #2;
        chk("exh_err2", {31'd0, error_o}, 32'd1);
        chk("exh_ready", {31'd0, ready_o}, 32'd1);
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("exh_fatal", {31'd0, fatal_o}, 32'd1);
        nxt();

        // Timeout: lane 1 never answers; expires on the 8th WAIT cycle
        drv(1'b1, 16'h300, 2'b01, 32'h21, 32'h0);
        #2;
        chk("to_c0_err", {31'd0, error_o}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            nxt();
            drv(1'b1, 16'h300, 2'b00, 32'h0, 32'h0);
            #2;
            chk("to_err", {31'd0, error_o}, (k == 7) ? 32'd1 : 32'd0);
            chk("to_ready", {31'd0, ready_o}, 32'd0);
        end
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("to_after_valid", {30'd0, valid_o}, 32'h0);
        chk("to_after_fatal", {31'd0, fatal_o}, 32'd1);
        nxt();

        // Abandon: requester drops valid_i while lanes finish
        drv(1'b1, 16'h400, 2'b01, 32'h55, 32'h0);
        nxt();
        drv(1'b0, 16'h400, 2'b10, 32'h0, 32'h55);
        #2;
        chk("abn_valid", {30'd0, valid_o}, 32'h2);
        chk("abn_ready", {31'd0, ready_o}, 32'd0);
        chk("abn_err", {31'd0, error_o}, 32'd0);
        nxt();
        drv(1'b1, 16'h500, 2'b11, 32'h66, 32'h66);
        exp_q.push_back(32'h66);
        #2;
        chk("abn_idle_ready", {31'd0, ready_o}, 32'd1);
        chk("abn_fatal_sticky", {31'd0, fatal_o}, 32'd1);
        nxt();

        // Reset in the middle of WAIT
        drv(1'b1, 16'h600, 2'b01, 32'h1, 32'h0);
        nxt();
        drv(1'b1, 16'h600, 2'b00, 32'h0, 32'h0);
        #2;
        chk("rstw_valid_pre", {30'd0, valid_o}, 32'h2);
        rst_ni = 1'b0;
        drv(1'b1, 16'h600, 2'b10, 32'h0, 32'h1);
        #1;
        chk("rstw_ready", {31'd0, ready_o}, 32'd0);
        chk("rstw_valid", {30'd0, valid_o}, 32'h0);
        chk("rstw_error", {31'd0, error_o}, 32'd0);
        chk("rstw_fatal", {31'd0, fatal_o}, 32'd0);
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        rst_ni = 1'b1;
        nxt();
        drv(1'b1, 16'h700, 2'b11, 32'h9, 32'h9);
        exp_q.push_back(32'h9);
        #2;
        chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
        chk("post_rst_fatal", {31'd0, fatal_o}, 32'd0);
        nxt();
        drv(1'b0, 16'h0, 2'b00, 32'h0, 32'h0);
        nxt();
        nxt();

        chk("sb_drained", exp_q.size(), 32'd0);
        chk("err_pulses", err_seen, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmr_instr_fork_join.md
Name: dmr_instr_fork_join

Overview:
- Reverse-direction companion of the DMR instruction join stage: one instruction-fetch requester drives NUM_OUT redundant instruction responders (replicated ICaches/ROMs).
- Forks each fetch address to all lanes and tracks per-lane completion, since lanes may answer in different cycles.
- Buffers returned words and compares them, returning data upstream only on agreement; on mismatch, retries and flags errors.
- Sits between a single (or already-joined) core fetch port and the replicated instruction memories.

Parameters:
- addr_t, logic, fetch address type
- data_t, logic, instruction data type
- NUM_OUT, 2, number of redundant responders (>=2)
- MaxRetries, 1, re-issues after a data mismatch before declaring fatal (0 = no retry)
- TimeoutCycles, 256, max cycles a request may wait for all lanes (0 = timeout disabled)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  requester address valid
- ready_o  out  1  request accepted; data_o valid this cycle
- addr_i  in  addr_t  requester fetch address
- data_o  out  data_t  instruction word to requester
- valid_o  out  NUM_OUT  per-lane address valid
- ready_i  in  NUM_OUT  per-lane accept; data_i[i] valid this cycle
- addr_o  out  NUM_OUT x addr_t  per-lane address
- data_i  in  NUM_OUT x data_t  per-lane instruction word
- error_o  out  1  single-cycle pulse on mismatch or timeout
- fatal_o  out  1  sticky until reset: retries exhausted or timeout

Behaviour:
- Protocol on both sides: ready in an address-valid cycle means the data of that same cycle is valid. There is no data-side handshake.
- Reset values:
  - Outputs: ready_o=0, valid_o='0, error_o=0, fatal_o=0.
  - Internal state: FSM=IDLE, done_q='0, addr_q='0, data buffers '0, retry_cnt=0, timer=0.
- IDLE:
  - addr_o[i]=addr_i; valid_o[i]=valid_i.
  - If valid_i and all ready_i=1 and all data_i equal data_i[0]: ready_o=1, data_o=data_i[0] (zero latency). Stay IDLE.
  - If valid_i and all ready_i=1 with disagreement: handled as a mismatch event (below), with addr_q<=addr_i.
  - If valid_i and not all ready_i=1: addr_q<=addr_i; done_q<=ready_i; capture data_i[i] for each ready lane; go WAIT.
- WAIT:
  - addr_o[i]=addr_q; valid_o[i]=!done_q[i].
  - Ready lanes set done_q[i] and capture data.
  - all_done = &(done_q|ready_i). Compare uses buffered data for lanes already done and live data_i for lanes ready this cycle.
  - all_done with match:
    - If valid_i && addr_i==addr_q: ready_o=1 and data_o=lane-0 word.
    - Otherwise the result is discarded (requester abandoned) and ready_o stays 0.
    - Either way, go IDLE.
- Mismatch event (all_done, disagreement):
  - error_o=1 for one cycle.
  - If retry_cnt<MaxRetries: retry_cnt++, done_q<='0, go RETRY.
  - Otherwise: fatal_o<=1, ready_o=1 (only if valid_i && addr_i==addr_q), data_o=lane-0 word, go IDLE.
- RETRY: one bubble cycle with valid_o='0. Next cycle go WAIT with done_q='0, re-issuing addr_q to all lanes.
- retry_cnt clears whenever the FSM returns to IDLE.
- Timer:
  - Counts cycles spent in WAIT/RETRY and clears on entry to IDLE.
  - When timer==TimeoutCycles-1 and not all_done: error_o pulse, fatal_o<=1, go IDLE, ready_o=0, done_q cleared.
  - Lanes still pending are dropped, i.e. valid_o falls without a handshake. This protocol violation is accepted only on this fatal path.
- Requester:
  - Must hold addr_i stable until ready_o.
  - Dropping valid_i or changing addr_i while in WAIT does not abort the downstream transaction. Lanes always complete the issued addr_q.
  - The new address is served only after the return to IDLE.
- Simultaneous events:
  - All lanes ready in the same cycle as a timeout expiry: completion wins.
  - fatal_o already set: operation continues normally and fatal_o stays 1.
- Reset mid-transaction: all state returns to reset values immediately (asynchronous). Outstanding lane requests are dropped.
- Comparison is full data_t equality against lane 0; there is no voting.

Decomposition:
- dmr_pkg holds the fork_join_state_e enum (IDLE, WAIT, RETRY).
- One sub-module, dmr_lane_tracker, instantiated NUM_OUT times:
  - holds done flag and data buffer;
  - outputs valid_o[i] and the effective (buffered-or-live) word.
- Timer, retry counter and FSM live in the top module.

Test Plan:
- Zero latency: NUM_OUT=2; valid_i=1, addr_i=0x100, both ready_i=1, data_i={0xA,0xA} -> ready_o=1, data_o=0xA same cycle, error_o=0.
- Skewed lanes: lane0 ready at cycle 0 (data 0x13), lane1 ready at cycle 3 (data 0x13) -> valid_o[0] low from cycle 1; ready_o=1, data_o=0x13 at cycle 3; addr_o[1]=0x100 held throughout.
- Mismatch then retry success: first response {0x5,0x6} -> error_o pulse, RETRY bubble, re-issue of 0x100; second response {0x5,0x5} -> ready_o=1, data_o=0x5, fatal_o=0.
- Retries exhausted: MaxRetries=1; mismatch twice -> two error_o pulses, fatal_o=1 sticky, ready_o=1 with lane-0 data on the second completion.
- Timeout: TimeoutCycles=8; lane1 never ready -> at cycle 7 error_o pulse, fatal_o=1, valid_o='0, ready_o never asserted.
- Abandon and reset: requester drops valid_i in WAIT -> lanes complete, ready_o stays 0, FSM back to IDLE. Then assert rst_ni=0 mid-WAIT -> all outputs 0 the same cycle.
